// File: rtl/led_frame_sequencer.sv
// APA102 frame sequencer: start frame, one 4-byte LED frame per pixel, end frame,
// handed byte by byte to a start/busy SPI byte writer.
module led_frame_sequencer #(
    parameter int NUM_LEDS  = 60,
    parameter int END_BYTES = 4
) (
    input  logic        strip_clk,
    input  logic        strip_reset_n,
    input  logic        frame_start,
    input  logic [4:0]  global_brightness,
    output logic [9:0]  pixel_index,
    input  logic [23:0] pixel_color,
    output logic        spi_start,
    output logic [7:0]  spi_data_out,
    input  logic        spi_busy,
    output logic        frame_busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        IDLE, START_FRAME, FETCH_ADDR, FETCH_LATCH, LED_FRAME, END_FRAME, DONE
    } state_t;

    localparam logic [9:0] LED_LAST = 10'(NUM_LEDS - 1);
    localparam logic [7:0] END_LAST = 8'(END_BYTES - 1);

    state_t      state_q;
    logic        wait_q;
    logic [7:0]  byte_cnt_q;
    logic [9:0]  led_cnt_q;
    logic [4:0]  bri_q;
    logic [23:0] pix_q;
    logic [9:0]  pixel_index_q;
    logic        spi_start_q;
    logic [7:0]  spi_data_q;
    logic        frame_busy_q;
    logic        frame_done_q;

    logic [7:0]  byte_d;
    logic        last_byte_d;

    // Byte to present and end-of-section flag for the current send state.
    always_comb begin
        byte_d      = 8'h00;
        last_byte_d = 1'b0;
        case (state_q)
            START_FRAME: last_byte_d = (byte_cnt_q == 8'd3);
            LED_FRAME: begin
                last_byte_d = (byte_cnt_q == 8'd3);
                case (byte_cnt_q[1:0])
                    2'd0:    byte_d = {3'b111, bri_q};
                    2'd1:    byte_d = pix_q[7:0];
                    2'd2:    byte_d = pix_q[15:8];
                    default: byte_d = pix_q[23:16];
                endcase
            end
            END_FRAME: begin
                byte_d      = 8'hFF;
                last_byte_d = (byte_cnt_q == END_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge strip_clk or negedge strip_reset_n) begin
        if (!strip_reset_n) begin
            state_q       <= IDLE;
            wait_q        <= 1'b0;
            byte_cnt_q    <= 8'd0;
            led_cnt_q     <= 10'd0;
            bri_q         <= 5'd0;
            pix_q         <= 24'd0;
            pixel_index_q <= 10'd0;
            spi_start_q   <= 1'b0;
            spi_data_q    <= 8'd0;
            frame_busy_q  <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        bri_q        <= global_brightness;
                        frame_busy_q <= 1'b1;
                        byte_cnt_q   <= 8'd0;
                        led_cnt_q    <= 10'd0;
                        wait_q       <= 1'b0;
                        state_q      <= START_FRAME;
                    end
                end
                START_FRAME, LED_FRAME, END_FRAME: begin
                    if (!wait_q) begin
                        // ISSUE: raise start, hold it until the writer reports busy
                        if (!spi_start_q) begin
                            spi_start_q <= 1'b1;
                            spi_data_q  <= byte_d;
                        end else if (spi_busy) begin
                            spi_start_q <= 1'b0;
                            wait_q      <= 1'b1;
                        end
                    end else if (!spi_busy) begin
                        wait_q <= 1'b0;
                        if (!last_byte_d) begin
                            byte_cnt_q <= byte_cnt_q + 8'd1;
                        end else begin
                            byte_cnt_q <= 8'd0;
                            case (state_q)
                                START_FRAME: begin
                                    // Present the index one cycle early so a registered
                                    // store has its data ready by the end of FETCH_LATCH.
                                    pixel_index_q <= led_cnt_q;
                                    state_q       <= FETCH_ADDR;
                                end
                                LED_FRAME: begin
                                    if (led_cnt_q == LED_LAST) begin
                                        state_q <= END_FRAME;
                                    end else begin
                                        led_cnt_q     <= led_cnt_q + 10'd1;
                                        pixel_index_q <= led_cnt_q + 10'd1;
                                        state_q       <= FETCH_ADDR;
                                    end
                                end
                                default: begin
                                    frame_done_q  <= 1'b1;
                                    frame_busy_q  <= 1'b0;
                                    pixel_index_q <= 10'd0;
                                    spi_data_q    <= 8'd0;
                                    state_q       <= DONE;
                                end
                            endcase
                        end
                    end
                end
                FETCH_ADDR: begin
                    pixel_index_q <= led_cnt_q;
                    state_q       <= FETCH_LATCH;
                end
                FETCH_LATCH: begin
                    pix_q   <= pixel_color;
                    state_q <= LED_FRAME;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_index  = pixel_index_q;
    assign spi_start    = spi_start_q;
    assign spi_data_out = spi_data_q;
    assign frame_busy   = frame_busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Directed bench: two sequencer instances (2 LEDs / 1 end byte, 1 LED / 4 end bytes),
// each with a start/busy writer model and a registered pixel store.
module tb_led_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: NUM_LEDS=2, END_BYTES=1
    logic        fs_a, st_a, sb_a, fb_a, fd_a;
    logic [4:0]  bri_a;
    logic [9:0]  pidx_a;
    logic [23:0] pcol_a;
    logic [7:0]  sd_a;
    logic [23:0] tab_a [0:1];

    led_frame_sequencer #(.NUM_LEDS(2), .END_BYTES(1)) dut_a (
        .strip_clk(clk), .strip_reset_n(rst_n), .frame_start(fs_a),
        .global_brightness(bri_a), .pixel_index(pidx_a), .pixel_color(pcol_a),
        .spi_start(st_a), .spi_data_out(sd_a), .spi_busy(sb_a),
        .frame_busy(fb_a), .frame_done(fd_a));

    always @(posedge clk) pcol_a <= tab_a[pidx_a[0]];

    logic [7:0] cap_a [0:1023];
    int ncap_a = 0, bcnt_a = 0, len_a = 13;
    bit rand_a = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_a <= 1'b0;
            bcnt_a <= 0;
        end else if (sb_a) begin
            if (bcnt_a <= 1) sb_a <= 1'b0;
            else bcnt_a <= bcnt_a - 1;
        end else if (st_a) begin
            sb_a <= 1'b1;
            bcnt_a <= rand_a ? int'($urandom_range(1, 40)) : len_a;
            cap_a[ncap_a % 1024] <= sd_a;
            ncap_a <= ncap_a + 1;
        end
    end

    int done_a = 0, gap_a = 0, viol_a = 0;
    bit both_a = 0;
    always @(posedge clk) begin
        if (fd_a) done_a++;
        if (st_a && !fb_a) gap_a++;
        if (st_a && sb_a && both_a) viol_a++;
        both_a = st_a && sb_a;
    end

    // ---------------- instance B: NUM_LEDS=1, END_BYTES=4
    logic        fs_b, st_b, sb_b, fb_b, fd_b;
    logic [9:0]  pidx_b;
    logic [23:0] pcol_b;
    logic [7:0]  sd_b;

    led_frame_sequencer #(.NUM_LEDS(1), .END_BYTES(4)) dut_b (
        .strip_clk(clk), .strip_reset_n(rst_n), .frame_start(fs_b),
        .global_brightness(5'h00), .pixel_index(pidx_b), .pixel_color(pcol_b),
        .spi_start(st_b), .spi_data_out(sd_b), .spi_busy(sb_b),
        .frame_busy(fb_b), .frame_done(fd_b));

    always @(posedge clk) pcol_b <= (pidx_b == 10'd0) ? 24'h123456 : 24'hDEAD00;

    logic [7:0] cap_b [0:63];
    int ncap_b = 0, bcnt_b = 0, done_b = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_b <= 1'b0;
            bcnt_b <= 0;
        end else if (sb_b) begin
            if (bcnt_b <= 1) sb_b <= 1'b0;
            else bcnt_b <= bcnt_b - 1;
        end else if (st_b) begin
            sb_b <= 1'b1;
            bcnt_b <= 3;
            cap_b[ncap_b % 64] <= sd_b;
            ncap_b <= ncap_b + 1;
        end
    end
    always @(posedge clk) if (fd_b) done_b++;

    // Expected byte i of an APA102 frame with up to two pixels.
    function automatic logic [7:0] exp_byte(input int i, input int n, input logic [4:0] bri,
                                            input logic [23:0] p0, input logic [23:0] p1);
        logic [23:0] p;
        int k;
        if (i < 4) return 8'h00;
        if (i >= 4 + 4 * n) return 8'hFF;
        k = i - 4;
        p = (k / 4 == 0) ? p0 : p1;
        case (k % 4)
            0:       return {3'b111, bri};
            1:       return p[7:0];
            2:       return p[15:8];
            default: return p[23:16];
        endcase
    endfunction

    task automatic check_stream_a(input string tag, input int base, input logic [4:0] bri);
        chk({tag, "_count"}, ncap_a - base, 13);
        for (int i = 0; i < 13; i++)
            chk($sformatf("%s_b%0d", tag, i), cap_a[(base + i) % 1024],
                exp_byte(i, 2, bri, tab_a[0], tab_a[1]));
    endtask

    task automatic wait_done_a(input string tag, input int budget);
        int d0 = done_a;
        int k = 0;
        while (done_a == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_a == d0) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic pulse_a(input logic [4:0] bri);
        @(negedge clk);
        fs_a = 1'b1;
        bri_a = bri;
        @(negedge clk);
        fs_a = 1'b0;
    endtask

    initial begin
        int base, d0, k;
        rst_n = 1'b0;
        fs_a = 1'b0;
        fs_b = 1'b0;
        bri_a = 5'h00;
        tab_a[0] = 24'h112233;
        tab_a[1] = 24'h445566;
        repeat (2) @(negedge clk);
        chk("rst_start", st_a, 0);
        chk("rst_data", sd_a, 0);
        chk("rst_busy", fb_a, 0);
        chk("rst_done", fd_a, 0);
        chk("rst_pidx", pidx_a, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, writer busy 13 cycles
        base = ncap_a;
        d0 = done_a;
        pulse_a(5'h1F);
        chk("accept_busy", fb_a, 1);
        chk("accept_nostart", st_a, 0);
        @(negedge clk);
        chk("first_start", st_a, 1);
        chk("first_data", sd_a, 8'h00);
        wait_done_a("basic", 2000);
        chk("basic_done_busy", fb_a, 0);
        chk("basic_done_data", sd_a, 0);
        @(negedge clk);
        chk("basic_done_once", done_a - d0, 1);
        check_stream_a("basic", base, 5'h1F);
        chk("basic_start_outside_busy", gap_a, 0);

        // frame_start held for 500 cycles mid-frame: exactly one frame
        len_a = 40;
        base = ncap_a;
        d0 = done_a;
        pulse_a(5'h1F);
        repeat (5) @(negedge clk);
        fs_a = 1'b1;
        repeat (500) @(negedge clk);
        chk("hold_still_busy", fb_a, 1);
        fs_a = 1'b0;
        wait_done_a("hold", 2000);
        repeat (20) @(negedge clk);
        chk("hold_one_done", done_a - d0, 1);
        chk("hold_idle", fb_a, 0);
        check_stream_a("hold", base, 5'h1F);

        // Random busy length 1..40
        rand_a = 1'b1;
        base = ncap_a;
        pulse_a(5'h1F);
        wait_done_a("rand", 3000);
        @(negedge clk);
        check_stream_a("rand", base, 5'h1F);
        chk("rand_overlap", viol_a, 0);
        rand_a = 1'b0;

        // Distinct colour per index, different brightness
        len_a = 5;
        tab_a[0] = 24'hA1B2C3;
        tab_a[1] = 24'h0F1E2D;
        base = ncap_a;
        pulse_a(5'h0A);
        wait_done_a("pix", 2000);
        @(negedge clk);
        check_stream_a("pix", base, 5'h0A);

        // Reset during the second LED frame
        len_a = 13;
        d0 = done_a;
        base = ncap_a;
        pulse_a(5'h1F);
        k = 0;
        while (ncap_a - base < 10 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_reached", (ncap_a - base >= 10), 1);
        chk("rst_mid_pre_busy", fb_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_start", st_a, 0);
        chk("rst_mid_data", sd_a, 0);
        chk("rst_mid_busy", fb_a, 0);
        chk("rst_mid_pidx", pidx_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("rst_mid_no_done", done_a - d0, 0);
        base = ncap_a;
        pulse_a(5'h1F);
        wait_done_a("after_rst", 2000);
        @(negedge clk);
        check_stream_a("after_rst", base, 5'h1F);

        // Instance B: one LED, brightness 0, four end bytes
        @(negedge clk);
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        k = 0;
        while (done_b == 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("b_done_once", done_b, 1);
        chk("b_count", ncap_b, 12);
        chk("b_header", cap_b[4], 8'hE0);
        chk("b_blue", cap_b[5], 8'h56);
        chk("b_green", cap_b[6], 8'h34);
        chk("b_red", cap_b[7], 8'h12);
        for (int i = 0; i < 4; i++) chk($sformatf("b_sof%0d", i), cap_b[i], 8'h00);
        for (int i = 8; i < 12; i++) chk($sformatf("b_eof%0d", i), cap_b[i], 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
